// File: rtl/reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reset_sequencer                                                 |
// | Purpose  : Generates the active-low system reset for the CPU, UART and     |
// |            clock-divider logic. Merges PLL lock, the debounced reset       |
// |            button and a CPU soft-reset strobe, stretches every reset to a  |
// |            minimum length, and records why the last reset happened.        |
// | Option   : define RESET_SEQ_WDT_EN to build the watchdog (cause 4).        |
// | Ports    : clk      - system clock (PLL output)                            |
// |            reset    - asynchronous active-high reset                       |
// |            lock     - PLL lock, asynchronous                               |
// |            sw_n     - reset push-button, asynchronous, 0 = pressed         |
// |            soft_req - one-cycle soft-reset strobe, clk domain              |
// |            wdt_kick - watchdog kick strobe, clk domain                     |
// |            reset_b  - registered system reset, active-low                  |
// |            cause    - last reset cause: 0 power/async, 1 lock loss,        |
// |                       2 button, 3 soft, 4 watchdog                         |
// |            running  - high while in RUN (LED drive)                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module reset_sequencer #(
  parameter int unsigned RESET_CYCLES    = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned WDT_CYCLES      = 4194304
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lock,
  input  logic       sw_n,
  input  logic       soft_req,
  input  logic       wdt_kick,
  output logic       reset_b,
  output logic [2:0] cause,
  output logic       running
);

  localparam int unsigned CNT_W = $clog2(RESET_CYCLES);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESET_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] CAUSE_POR  = 3'd0;
  localparam logic [2:0] CAUSE_LOCK = 3'd1;
  localparam logic [2:0] CAUSE_BTN  = 3'd2;
  localparam logic [2:0] CAUSE_SOFT = 3'd3;
  localparam logic [2:0] CAUSE_WDT  = 3'd4;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       cause_nxt;
  logic             wdt_expire;

  // Two-flop synchronisers. The button idles released (1) so that a reset
  // never looks like a press.
  logic lock_meta, lock_s;
  logic sw_meta, sw_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      sw_meta   <= 1'b1;
      sw_s      <= 1'b1;
    end else begin
      lock_meta <= lock;
      lock_s    <= lock_meta;
      sw_meta   <= sw_n;
      sw_s      <= sw_meta;
    end
  end

  // Debounce: the accepted level flips only after the synchronised input has
  // disagreed with it on DEBOUNCE_CYCLES consecutive cycles.
  logic            btn_stable;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_stable <= 1'b1;
      db_cnt     <= '0;
    end else if (sw_s == btn_stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_stable <= sw_s;
      db_cnt     <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

`ifdef RESET_SEQ_WDT_EN
  localparam int unsigned      WDT_W    = $clog2(WDT_CYCLES);
  // Expiry fires on the cycle whose increment would reach WDT_CYCLES-1, so
  // the terminal cycle itself can still be rescued by a kick.
  localparam logic [WDT_W-1:0] WDT_TERM = WDT_W'(WDT_CYCLES - 2);

  logic [WDT_W-1:0] wdt_cnt;

  // Held at zero outside RUN, which also gives a clean start on RUN entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_cnt <= '0;
    end else if ((state != RUN) || wdt_kick) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + WDT_W'(1);
    end
  end

  assign wdt_expire = (state == RUN) && !wdt_kick && (wdt_cnt == WDT_TERM);
`else
  // Watchdog not built: this tie-off is constant 0 for any legal WDT_CYCLES.
  assign wdt_expire = wdt_kick & (WDT_CYCLES == 0);
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cause_nxt = cause;
    case (state)
      HOLD: begin
        if (lock_s && btn_stable) begin
          state_nxt = STRETCH;
          cnt_nxt   = CNT_LOAD;
        end
      end
      STRETCH: begin
        // An abort here keeps the cause of the reset that got us here.
        if (!lock_s || !btn_stable) begin
          state_nxt = HOLD;
        end else if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = HOLD;
          cause_nxt = CAUSE_LOCK;
        end else if (!btn_stable) begin
          state_nxt = HOLD;
          cause_nxt = CAUSE_BTN;
        end else if (soft_req) begin
          state_nxt = HOLD;
          cause_nxt = CAUSE_SOFT;
        end else if (wdt_expire) begin
          state_nxt = HOLD;
          cause_nxt = CAUSE_WDT;
        end
      end
      default: state_nxt = HOLD;
    endcase
  end

  // Outputs are registered from the next state so reset_b is glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= HOLD;
      cnt     <= '0;
      cause   <= CAUSE_POR;
      reset_b <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cause   <= cause_nxt;
      reset_b <= (state_nxt == RUN);
      running <= (state_nxt == RUN);
    end
  end

endmodule
`default_nettype wire
